mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Multicycle control sequencer for the 8-bit-instruction processor. Steps each instruction through FETCH/DECODE/EXEC/WB states and drives every datapath enable and mux select, asserting register-file writes only in the writeback cycle. It sits between the IR/flag registers and the datapath and owns halt and retire tracking.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  4  IR[3:0], valid from DECODE onward
flag_n  in  1  registered N flag from datapath
flag_z  in  1  registered Z flag from datapath
pc_write  out  1  PC load enable
addr_sel  out  1  memory address mux: 1 = PC, 0 = R2 data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_load  out  1  IR load enable
mdr_load  out  1  MDR load enable
r1_sel  out  1  1 = force R1 read-address to reg 1 (ORI)
ab_load  out  1  A/B operand register load
alu1_sel  out  1  0 = PC, 1 = A
alu2_sel  out  3  0 = B, 1 = const 1, 2 = sext imm4, 3 = zext imm5, 4 = imm3 shift
alu_op  out  3  0 = add, 1 = sub, 3 = nand, 4 = or, 5 = shift
aluout_write  out  1  ALUout register load
flag_write  out  1  N/Z register load
rf_write  out  1  register-file write enable
regw_sel  out  1  RF write-address mux: 1 = reg 1 (ORI), 0 = R1 field
reg_in_sel  out  1  RF write data: 1 = MDR, 0 = ALUout
halted  out  1  high while in HALT
retire  out  1  1-cycle pulse in the last cycle of each instruction
retire_cnt  out  CNT_W  retired instructions, saturates at all-ones

Behaviour:
- Reset (sync): next state RST. In RST all outputs 0, retire_cnt = 0. RST -> FETCH unconditionally.
- Outputs are a Moore decode of the registered state plus opcode. No output depends combinationally on the flags except pc_write in BR.
- FETCH: mem_read, addr_sel=1, ir_load, alu1_sel=0, alu2_sel=1, alu_op=add, pc_write. -> DECODE.
- DECODE: ab_load; r1_sel=1 if opcode[2:0]=111. Computes PC+sext imm4 into ALUout (alu1_sel=0, alu2_sel=2, aluout_write).
- Next state from DECODE:
  - 0000 load, 0010 store -> MEM
  - 0100 add, 0110 sub, 1000 nand, x111 ori, x011 shift -> EXEC
  - 0101 bz, 1001 bnz, 1101 bpz -> BR
  - 0001 stop -> HALT
  - 1010 nop and all undefined opcodes -> FETCH, with retire
- EXEC: alu1_sel=1, aluout_write, flag_write. alu2_sel = B / B / B / imm5 / imm3. alu_op = add / sub / nand / or / shift. -> WB.
- MEM: addr_sel=0, mem_read + mdr_load for load -> WB. mem_write for store -> FETCH, with retire.
- BR: alu1_sel=0, alu2_sel=2, alu_op=add. pc_write = Z (bz), ~Z (bnz), ~N (bpz). Flags are sampled this cycle. -> FETCH, with retire.
- WB: rf_write=1. reg_in_sel=1 only for load. regw_sel=1 only for ORI. -> FETCH, with retire.
- HALT: halted=1, all strobes 0, remains until reset. Retire pulses once on HALT entry.
- Cycle counts: nop/undef 2; store/branch 3; ALU ops and load 4.
- retire_cnt increments on retire, holds at 2^CNT_W-1.
- Reset asserted mid-instruction: the following cycle is RST with no rf_write/mem_write/pc_write. Partially executed instructions are not retired.
- Opcode changing outside DECODE/EXEC/MEM/BR/WB is ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum: RST, FETCH, DECODE, EXEC, MEM, BR, WB, HALT
  - opcode constants (4-bit, with 3-bit ORI/shift matching on [2:0])
  - alu_op and alu2_sel encodings
- One natural sub-module, mc_wb_decode: combinational opcode -> {rf_write_en, regw_sel, reg_in_sel}, gated by the FSM in WB.

Test Plan:
- Reset then add (0100): after 1 cycle state FETCH. rf_write high exactly in cycle 4 with reg_in_sel=0. retire_cnt=1.
- Load 0000 then store 0010: load asserts mdr_load in MEM, rf_write with reg_in_sel=1 in WB. Store asserts mem_write once, never rf_write. retire_cnt=2 after 7 cycles.
- ORI 0111 and 1111: r1_sel=1 in DECODE, alu_op=4 and alu2_sel=3 in EXEC, rf_write with regw_sel=1 in WB.
- Branches with flags: bz with Z=1 -> pc_write in BR; bz Z=0 -> none; bnz Z=0 -> taken; bpz N=1 -> not taken. Each takes 3 cycles.
- Stop 0001: halted=1 from cycle 3, all strobes 0 for 20 cycles, retire_cnt frozen. Reset clears halted the next cycle.
- Reset asserted in EXEC of a sub: no rf_write ever issued, retire_cnt unchanged (0). Nop and undefined 1110 each retire in 2 cycles with no writes.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multicycle control sequencer:
//               FSM state codes, 4-bit opcodes (ORI/shift matched on [2:0]),
//               ALU operation and ALU operand-2 mux encodings, and the
//               DECODE-state dispatch function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_BR     = 3'd5;
    localparam logic [2:0] ST_WB     = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

    // Full 4-bit opcodes
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // ORI and shift ignore opcode[3]
    localparam logic [2:0] OP3_ORI   = 3'b111;
    localparam logic [2:0] OP3_SHIFT = 3'b011;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_NAND  = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SHIFT = 3'd5;

    // ALU operand-2 mux encodings
    localparam logic [2:0] A2_B     = 3'd0;
    localparam logic [2:0] A2_ONE   = 3'd1;
    localparam logic [2:0] A2_SIMM4 = 3'd2;
    localparam logic [2:0] A2_ZIMM5 = 3'd3;
    localparam logic [2:0] A2_IMM3  = 3'd4;

    function automatic logic is_ori(input logic [3:0] op);
        return (op[2:0] == OP3_ORI);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op[2:0] == OP3_SHIFT);
    endfunction

    // State following DECODE. Anything not recognised (nop and the
    // undefined codes) drops straight back to FETCH.
    function automatic logic [2:0] decode_next(input logic [3:0] op);
        logic [2:0] nxt;
        nxt = ST_FETCH;
        if (is_ori(op) || is_shift(op)) begin
            nxt = ST_EXEC;
        end else begin
            case (op)
                OP_LOAD, OP_STORE:       nxt = ST_MEM;
                OP_ADD, OP_SUB, OP_NAND: nxt = ST_EXEC;
                OP_BZ, OP_BNZ, OP_BPZ:   nxt = ST_BR;
                OP_STOP:                 nxt = ST_HALT;
                default:                 nxt = ST_FETCH;
            endcase
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_fsm_wb_decode.sv
// ============================================================================
// Module      : mc_wb_decode
// Description : Writeback-stage register-file control. Decodes the opcode
//               into RF write enable, write-address select and write-data
//               select; everything is forced low outside WB.
// Ports       : in_wb       - FSM is in the WB state
//               opcode      - IR[3:0]
//               rf_write_en - register-file write enable
//               regw_sel    - 1 = write reg 1 (ORI), 0 = R1 field
//               reg_in_sel  - 1 = MDR (load), 0 = ALUout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wb_decode
    import mc_ctrl_pkg::*;
(
    input  logic       in_wb,
    input  logic [3:0] opcode,
    output logic       rf_write_en,
    output logic       regw_sel,
    output logic       reg_in_sel
);

    // WB is only reachable from ALU ops and load, so every WB cycle writes.
    assign rf_write_en = in_wb;
    assign regw_sel    = in_wb & is_ori(opcode);
    assign reg_in_sel  = in_wb & (opcode == OP_LOAD);

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multicycle control sequencer for the 8-bit-instruction
//               processor. Steps each instruction through FETCH/DECODE/
//               EXEC|MEM|BR/WB, drives all datapath enables and mux selects
//               as a Moore decode of state + opcode, and tracks halt and
//               retired-instruction count (saturating).
// Ports       : clock, reset (sync, active-high); opcode, flag_n, flag_z in;
//               datapath strobes/selects, halted, retire, retire_cnt out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             flag_n,
    input  logic             flag_z,
    output logic             pc_write,
    output logic             addr_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             r1_sel,
    output logic             ab_load,
    output logic             alu1_sel,
    output logic [2:0]       alu2_sel,
    output logic [2:0]       alu_op,
    output logic             aluout_write,
    output logic             flag_write,
    output logic             rf_write,
    output logic             regw_sel,
    output logic             reg_in_sel,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [2:0]       w_dec_next;
    logic [CNT_W-1:0] r_cnt;

    assign w_dec_next = decode_next(opcode);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (retire && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

    assign retire_cnt = r_cnt;

    mc_wb_decode u_wb_decode (
        .in_wb       (r_state == ST_WB),
        .opcode      (opcode),
        .rf_write_en (rf_write),
        .regw_sel    (regw_sel),
        .reg_in_sel  (reg_in_sel)
    );

    always_comb begin
        w_next       = r_state;
        pc_write     = 1'b0;
        addr_sel     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        r1_sel       = 1'b0;
        ab_load      = 1'b0;
        alu1_sel     = 1'b0;
        alu2_sel     = A2_B;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        flag_write   = 1'b0;
        halted       = 1'b0;
        retire       = 1'b0;

        case (r_state)
            ST_RST: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                // PC <= PC + 1 while the instruction is read into IR
                mem_read = 1'b1;
                addr_sel = 1'b1;
                ir_load  = 1'b1;
                alu2_sel = A2_ONE;
                pc_write = 1'b1;
                w_next   = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target PC + sext(imm4) is precomputed into ALUout
                ab_load      = 1'b1;
                r1_sel       = is_ori(opcode);
                alu2_sel     = A2_SIMM4;
                aluout_write = 1'b1;
                w_next       = w_dec_next;
                // nop/undefined complete here; stop retires on HALT entry
                retire       = (w_dec_next == ST_FETCH) || (w_dec_next == ST_HALT);
            end
            ST_EXEC: begin
                alu1_sel     = 1'b1;
                aluout_write = 1'b1;
                flag_write   = 1'b1;
                w_next       = ST_WB;
                if (opcode == OP_SUB) begin
                    alu_op = ALU_SUB;
                end else if (opcode == OP_NAND) begin
                    alu_op = ALU_NAND;
                end else if (is_ori(opcode)) begin
                    alu2_sel = A2_ZIMM5;
                    alu_op   = ALU_OR;
                end else if (is_shift(opcode)) begin
                    alu2_sel = A2_IMM3;
                    alu_op   = ALU_SHIFT;
                end
            end
            ST_MEM: begin
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    mdr_load = 1'b1;
                    w_next   = ST_WB;
                end else begin
                    mem_write = 1'b1;
                    retire    = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_BR: begin
                alu2_sel = A2_SIMM4;
                retire   = 1'b1;
                w_next   = ST_FETCH;
                case (opcode)
                    OP_BZ:   pc_write = flag_z;
                    OP_BNZ:  pc_write = ~flag_z;
                    OP_BPZ:  pc_write = ~flag_n;
                    default: pc_write = 1'b0;
                endcase
            end
            ST_WB: begin
                retire = 1'b1;
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_RST;
            end
        endcase
    end

endmodule

`default_nettype wire
